// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
//
// Main control unit for the 5-stage RISC-V pipeline. The ID-stage opcode is
// decoded into a control bundle, which then travels through the ID/EX, EX/MEM
// and MEM/WB control registers alongside the datapath. Stall and flush
// requests insert a bubble into ID/EX only. A HALT instruction that reaches EX
// starts a drain sequence. The sequence freezes fetch for DRAIN_CYCLES cycles
// and then parks the core in a sticky halted state.
//
// Optional feature (compile-time macro ILLEGAL_TRAP_EN):
//   defined   - adds the sticky 'illegal' output. An accepted unknown opcode
//               sets it and drains the core exactly like HALT.
//   undefined - unknown opcodes decode to a silent bubble. 'illegal' is absent.
//
// Parameters:
//   OPCODE_W      opcode field width
//   DRAIN_CYCLES  cycles spent in DRAIN before halted asserts (1..15)
//   CNT_W         drain counter width, 2**CNT_W > DRAIN_CYCLES
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   opcode_id     opcode of the instruction in ID
//   valid_id      ID holds a real instruction
//   stall         load-use stall from the hazard unit
//   flush         taken branch/jump resolved in EX
//   ex_alusrc     ALU operand B = immediate                   (ID/EX)
//   ex_aluop      00 add, 01 branch cmp, 10 R-type, 11 I/LUI  (ID/EX)
//   ex_branch     control-transfer instruction                (ID/EX)
//   ex_jalr_sel   target = rs1 + imm                          (ID/EX)
//   mem_memread   data memory read                            (EX/MEM)
//   mem_memwrite  data memory write                           (EX/MEM)
//   wb_regwrite   register file write enable                  (MEM/WB)
//   wb_memtoreg   WB data from memory                         (MEM/WB)
//   wb_rwsel      00 ALU/mem, 01 PC+4, 10 immediate           (MEM/WB)
//   fetch_freeze  hold PC and IF/ID (DRAIN and HALTED)
//   halted        core halted, sticky until reset
//   illegal       unknown opcode trapped (ILLEGAL_TRAP_EN only)
//
// FSM states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | normal issue; ID/EX loads decoded bundles
//   ST_DRAIN  | halt seen in EX; fetch frozen, counter runs to DRAIN_CYCLES-1
//   ST_HALTED | terminal; fetch frozen, halted high until reset
// ---------------------------------------------------------------------------
module pipe_ctrl_unit #(
    parameter int OPCODE_W     = 7,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_id,
    input  logic                valid_id,
    input  logic                stall,
    input  logic                flush,
    output logic                ex_alusrc,
    output logic [1:0]          ex_aluop,
    output logic                ex_branch,
    output logic                ex_jalr_sel,
    output logic                mem_memread,
    output logic                mem_memwrite,
    output logic                wb_regwrite,
    output logic                wb_memtoreg,
    output logic [1:0]          wb_rwsel,
    output logic                fetch_freeze,
    output logic                halted
`ifdef ILLEGAL_TRAP_EN
   ,output logic                illegal
`endif
);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(7'b0110111);
    localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b0000001);

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // Full bundle held in ID/EX; later stages keep only what they consume.
    typedef struct packed {
        logic       alusrc;
        logic [1:0] aluop;
        logic       branch;
        logic       jalr_sel;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] rwsel;
        logic       is_halt;
    } idex_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] rwsel;
    } exmem_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] rwsel;
    } memwb_t;

    idex_t      dec;
    idex_t      idex_d,  idex_q;
    exmem_t     exmem_d, exmem_q;
    memwb_t     memwb_d, memwb_q;
    state_e     state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic       fetch_freeze_d, fetch_freeze_q;
    logic       halted_d, halted_q;
    logic       accept;
    logic       is_known;

    logic is_r, is_lw, is_sw, is_br, is_jal, is_jalr, is_i, is_lui, is_halt_op;

    // -----------------------------------------------------------------------
    // ID-stage decode
    // -----------------------------------------------------------------------
    always_comb begin
        is_r       = (opcode_id == OP_R);
        is_lw      = (opcode_id == OP_LW);
        is_sw      = (opcode_id == OP_SW);
        is_br      = (opcode_id == OP_BR);
        is_jal     = (opcode_id == OP_JAL);
        is_jalr    = (opcode_id == OP_JALR);
        is_i       = (opcode_id == OP_I);
        is_lui     = (opcode_id == OP_LUI);
        is_halt_op = (opcode_id == OP_HALT);
        is_known   = is_r | is_lw | is_sw | is_br | is_jal | is_jalr |
                     is_i | is_lui | is_halt_op;

        dec          = '0;
        dec.alusrc   = is_lw | is_sw | is_i | is_jalr | is_lui;
        dec.branch   = is_br | is_jal | is_jalr;
        dec.jalr_sel = is_jalr;
        dec.memread  = is_lw;
        dec.memwrite = is_sw;
        dec.regwrite = is_r | is_lw | is_i | is_jal | is_jalr | is_lui;
        dec.memtoreg = is_lw;

        if (is_r)
            dec.aluop = 2'b10;
        else if (is_br)
            dec.aluop = 2'b01;
        else if (is_i | is_lui)
            dec.aluop = 2'b11;
        else
            dec.aluop = 2'b00;

        if (is_jal | is_jalr)
            dec.rwsel = 2'b01;
        else if (is_lui)
            dec.rwsel = 2'b10;
        else
            dec.rwsel = 2'b00;

`ifdef ILLEGAL_TRAP_EN
        // A trapped opcode drains the core through the same path as HALT.
        dec.is_halt = is_halt_op | ~is_known;
`else
        dec.is_halt = is_halt_op;
`endif
    end

    // -----------------------------------------------------------------------
    // Pipeline control registers: only ID/EX sees bubbles, later stages
    // always advance so in-flight instructions complete.
    // -----------------------------------------------------------------------
    always_comb begin
        accept = valid_id & ~stall & ~flush & (state_q == ST_RUN);
        idex_d = accept ? dec : '0;

        exmem_d          = '0;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.rwsel    = idex_q.rwsel;

        memwb_d          = '0;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.rwsel    = exmem_q.rwsel;
    end

    // -----------------------------------------------------------------------
    // Halt-drain FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (idex_q.is_halt) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST)
                    state_d = ST_HALTED;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        // Status outputs are registered copies of the next state so they line
        // up with the state register itself.
        fetch_freeze_d = (state_d != ST_RUN);
        halted_d       = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q         <= '0;
            exmem_q        <= '0;
            memwb_q        <= '0;
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            fetch_freeze_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            idex_q         <= idex_d;
            exmem_q        <= exmem_d;
            memwb_q        <= memwb_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fetch_freeze_q <= fetch_freeze_d;
            halted_q       <= halted_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_d, illegal_q;

    always_comb begin
        illegal_d = illegal_q | (accept & ~is_known);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;
`endif

    assign ex_alusrc    = idex_q.alusrc;
    assign ex_aluop     = idex_q.aluop;
    assign ex_branch    = idex_q.branch;
    assign ex_jalr_sel  = idex_q.jalr_sel;
    assign mem_memread  = exmem_q.memread;
    assign mem_memwrite = exmem_q.memwrite;
    assign wb_regwrite  = memwb_q.regwrite;
    assign wb_memtoreg  = memwb_q.memtoreg;
    assign wb_rwsel     = memwb_q.rwsel;
    assign fetch_freeze = fetch_freeze_q;
    assign halted       = halted_q;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined main control unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It inserts bubbles on stall or flush requests and runs a halt-drain state machine. It sits beside the datapath pipeline registers and is driven by the hazard unit (stall) and the EX-stage branch logic (flush).

Parameters:
OPCODE_W, 7, opcode field width
DRAIN_CYCLES, 3, cycles spent in DRAIN after HALT enters EX before halted asserts (1..15)
CNT_W, 4, drain counter width; must satisfy 2^CNT_W > DRAIN_CYCLES

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode_id  in  OPCODE_W  opcode of instruction in ID
valid_id  in  1  ID holds a real instruction
stall  in  1  load-use stall from hazard unit
flush  in  1  branch/jump taken, resolved in EX
ex_alusrc  out  1  ALU operand B = immediate
ex_aluop  out  2  00 add (LW/SW/JAL/JALR), 01 branch compare, 10 R-type, 11 I-type/LUI
ex_branch  out  1  control-transfer instruction in EX
ex_jalr_sel  out  1  target = rs1+imm
mem_memread  out  1  data memory read
mem_memwrite  out  1  data memory write
wb_regwrite  out  1  register file write enable
wb_memtoreg  out  1  WB data from memory
wb_rwsel  out  2  00 ALU/mem, 01 PC+4, 10 immediate (LUI)
fetch_freeze  out  1  hold PC and IF/ID
halted  out  1  core halted (sticky until reset)

Behaviour:
- Decode (combinational, ID stage). Opcodes: R 0110011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, I 0010011, LUI 0110111, HALT 0000001.
- alusrc = LW|SW|I|JALR|LUI.
- regwrite = R|LW|I|JAL|JALR|LUI.
- memtoreg = memread = LW; memwrite = SW.
- branch = BR|JAL|JALR; jalr_sel = JALR.
- rwsel = 01 for JAL/JALR, 10 for LUI, else 00.
- Unknown opcode and HALT decode to an all-zero bundle. HALT also sets an internal is_halt bit.
- ID/EX register loads a bubble (all zero, is_halt=0) if any of: !valid_id, stall, flush, or state != RUN. Otherwise it loads the decoded bundle.
- EX/MEM and MEM/WB registers always advance. Stall and flush never freeze them.
- Outputs are driven directly from the registers: ex_* from ID/EX, mem_* from EX/MEM, wb_* from MEM/WB. Latency from opcode_id to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Flush and stall in the same cycle: a single bubble is inserted, identical to flush alone.
- FSM states:
  - RUN to DRAIN: the cycle after ID/EX.is_halt=1; the counter loads 0.
  - DRAIN: the counter increments each cycle. When counter == DRAIN_CYCLES-1, move to HALTED.
  - HALTED: terminal until reset.
- fetch_freeze = 1 in DRAIN and HALTED. halted = 1 only in HALTED.
- Reset (async, any time including mid-DRAIN): all pipeline control registers clear to zero, FSM goes to RUN, counter clears to 0. All outputs read 0 during reset and on the first cycle after release.
- valid_id X while rst_n=0 is ignored.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit, sticky). An unknown opcode with valid_id=1, stall=0, flush=0 and state RUN sets illegal on the next edge and causes RUN to DRAIN, exactly as HALT does. illegal clears only on reset.
- Undefined: the port is absent and unknown opcodes are silent bubbles.

Test Plan:
- Reset, then valid_id=1 with opcode_id=0110011 (R) -> next cycle ex_aluop=10, ex_alusrc=0; 2 cycles later wb_regwrite=1, wb_rwsel=00.
- LW then SW back-to-back -> mem_memread=1 in cycle 2 and mem_memwrite=1 in cycle 3; wb_memtoreg=1 in cycle 3 only.
- JAL with flush=1 in the same cycle -> ex_* all 0 next cycle, and no regwrite reaches WB. Same JAL without flush -> ex_branch=1, wb_rwsel=01.
- LUI issued while stall=1 for 1 cycle, then re-issued -> one bubble in EX, then ex_aluop=11, and wb_rwsel=10 three cycles after re-issue.
- HALT with DRAIN_CYCLES=3 -> fetch_freeze=1 from cycle 2; halted=1 at cycle 5 and stays high. rst_n low in cycle 3 (mid-DRAIN) -> fetch_freeze=0 and halted=0 immediately.
- ILLEGAL_TRAP_EN defined, opcode 1111111 -> illegal=1 next cycle and fetch_freeze=1. Without the macro, the same stimulus gives a plain bubble and no freeze.
